// File: rtl/if_fetch_unit_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit_pkg
// Description : Shared types and default constants for the fetch unit:
//               fetch FSM state encoding, reset PC and the NOP word.
// Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_unit_pkg;

    // Fetch FSM: issue request, wait for response, hold instruction for IF/ID
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } fetch_state_e;

    // Default PC loaded on reset
    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;

    // addi x0, x0, 0 - presented to IF/ID whenever no instruction is valid
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;

endpackage : if_fetch_unit_pkg
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Fetch stage. Holds the architectural fetch PC, issues one
//               instruction-memory request at a time over a valid/ready
//               request / valid response interface, and presents the fetched
//               word to the IF/ID register. Handles hazard stalls and
//               control-flow redirects; responses made stale by a redirect
//               are discarded via a drop flag.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST,
    input  logic [31:0] PC_In,
    input  logic        Redirect,
    input  logic        StallF,
    output logic [31:0] PCF,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] InstrF,
    output logic        InstrF_valid,
    output logic [31:0] InstrF_pc,
    output logic        FetchBusy
);

    fetch_state_e state_q;
    logic [31:0]  pcf_q;
    logic [31:0]  req_addr_q;
    logic         drop_q;
    logic [31:0]  instr_q;
    logic [31:0]  instr_pc_q;
    logic         instr_valid_q;

    // Fetch FSM: PC, request address, drop flag and IF/ID outputs all registered here
    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            state_q       <= S_REQ;
            pcf_q         <= RESET_PC;
            req_addr_q    <= RESET_PC;
            drop_q        <= 1'b0;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            // A redirect always retargets the architectural PC, whatever the state
            if (Redirect) begin
                pcf_q <= PC_In;
            end

            case (state_q)
                S_REQ: begin
                    // The request in flight keeps its old address; a redirect
                    // only marks its eventual response as stale.
                    if (Redirect) begin
                        drop_q <= 1'b1;
                    end
                    if (imem_req_ready) begin
                        state_q <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (Redirect || drop_q) begin
                            // Stale response: refetch from the current target.
                            // On a coincident redirect PCF is being loaded this
                            // same edge, so take the target straight from PC_In.
                            drop_q     <= 1'b0;
                            req_addr_q <= Redirect ? PC_In : pcf_q;
                            state_q    <= S_REQ;
                        end else begin
                            instr_q       <= imem_rsp_data;
                            instr_pc_q    <= req_addr_q;
                            instr_valid_q <= 1'b1;
                            state_q       <= S_OUT;
                        end
                    end else if (Redirect) begin
                        drop_q <= 1'b1;
                    end
                end

                S_OUT: begin
                    // Redirect dominates the stall; either way the next fetch
                    // goes to PC_In (the NPC generator supplies PCF+4 when sequential).
                    if (Redirect || !StallF) begin
                        pcf_q         <= PC_In;
                        req_addr_q    <= PC_In;
                        instr_q       <= NOP_INSTR;
                        instr_valid_q <= 1'b0;
                        state_q       <= S_REQ;
                    end
                end

                default: begin
                    state_q <= S_REQ;
                end
            endcase
        end
    end

    // Request is held off while reset is asserted so nothing is accepted in the reset cycle
    assign imem_req_valid = (state_q == S_REQ) && !CPU_RST;
    assign imem_req_addr  = req_addr_q;
    assign PCF            = pcf_q;
    assign InstrF         = instr_q;
    assign InstrF_pc      = instr_pc_q;
    assign InstrF_valid   = instr_valid_q;
    assign FetchBusy      = (state_q == S_REQ) || (state_q == S_WAIT);

endmodule : if_fetch_unit
`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Fetch-stage consumer of the next-PC value selected by the NPC generator.
- Holds the architectural fetch PC (PCF), issues one request at a time to instruction memory over a valid/ready request and valid response interface, and presents the fetched instruction to the IF/ID register.
- Handles hazard-unit stalls and control-flow redirects.
- Discards in-flight responses that a redirect has made stale.

Parameters:
- RESET_PC, 32'h0000_0000, PCF value after reset.
- NOP_INSTR, 32'h0000_0013, value driven on InstrF whenever InstrF_valid=0.

Ports:
- CPU_CLK  in  1  clock; all state updates on rising edge
- CPU_RST  in  1  reset, synchronous, active-high
- PC_In  in  32  next PC from the NPC generator
- Redirect  in  1  high when NPC selected a non-sequential target (JalrE|BranchE|JalD)
- StallF  in  1  hazard unit holds fetch/IF-ID
- PCF  out  32  current fetch PC, fed back to the NPC generator
- imem_req_valid  out  1  request valid
- imem_req_addr  out  32  request word address
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response data valid
- imem_rsp_data  in  32  response instruction word
- InstrF  out  32  instruction to IF/ID
- InstrF_valid  out  1  InstrF/InstrF_pc are meaningful
- InstrF_pc  out  32  PC of InstrF
- FetchBusy  out  1  high in S_REQ/S_WAIT; the hazard unit uses it to stall downstream

Behaviour:
- Clocking and reset: one clock, CPU_CLK. Reset is synchronous, active-high, on CPU_RST.
- Reset values:
  - PCF=RESET_PC.
  - State=S_REQ.
  - imem_req_valid=0 during the reset cycle; it asserts in the first cycle after reset.
  - imem_req_addr=RESET_PC.
  - InstrF_valid=0, InstrF=NOP_INSTR, InstrF_pc=0.
  - drop flag=0.
- S_REQ:
  - imem_req_valid=1; imem_req_addr comes from an internal req_addr register, not PCF.
  - req_addr/valid stay stable until imem_req_ready=1.
  - On accept, go to S_WAIT.
- S_WAIT:
  - Waits for imem_rsp_valid. The response arrives no earlier than the cycle after accept.
  - On a response with drop=0: latch InstrF=imem_rsp_data, InstrF_pc=req_addr, InstrF_valid=1, go to S_OUT.
  - On a response with drop=1: clear drop, req_addr<=PCF, go to S_REQ.
- S_OUT:
  - Holds InstrF_valid=1 and stable outputs while StallF=1.
  - When StallF=0: PCF<=PC_In, req_addr<=PC_In, InstrF_valid<=0, go to S_REQ.
- Redirect=1 (dominates StallF), in any state:
  - PCF<=PC_In on that edge.
  - In S_OUT: InstrF_valid<=0, req_addr<=PC_In, go to S_REQ.
  - In S_REQ with ready=0: the request completes at the old address; drop<=1.
  - In S_REQ with ready=1: drop<=1.
  - In S_WAIT: drop<=1. If rsp_valid arrives in the same cycle, that response is discarded, req_addr<=PC_In, go to S_REQ.
- Sequential PC: in S_OUT the sequential increment is the NPC generator's job (PC_In=PCF+4); this block never adds to the PC.
- Stray responses: imem_rsp_valid outside S_WAIT is ignored.
- Reset mid-operation: the outstanding request is abandoned and drop clears. Instruction memory is reset on the same CPU_RST, so it must not respond afterwards.
- Latency: with ready=1 at issue and the response one cycle later, InstrF_valid rises 2 cycles after entering S_REQ. Throughput is one instruction per 3 cycles minimum.
- Widths: PC arithmetic is 32-bit wrap. No alignment check: the low 2 bits of PC_In pass through unchanged.

Decomposition:
- Shared package holds:
  - state enum {S_REQ, S_WAIT, S_OUT} (2-bit encoding);
  - NOP_INSTR and RESET_PC defaults.
- Single module; no sub-module is natural.

Test Plan:
- Reset, ready=1, response one cycle after accept with data 0x00500093 → req_addr=0x0; InstrF=0x00500093, InstrF_pc=0x0, InstrF_valid=1 two cycles after reset release.
- S_OUT, StallF=1 for 3 cycles, PC_In=0x4 → outputs frozen, PCF=0x0 for all 3 cycles; after release, next req_addr=0x4.
- Redirect=1, PC_In=0x100 in S_WAIT; old response arrives one cycle later → response discarded, InstrF_valid stays 0, next request address 0x100.
- Redirect in S_REQ with ready=0 for 2 cycles → addr stays at old value until accept; its response is dropped; then a request at the new PC is issued.
- Redirect and StallF both high in S_OUT, PC_In=0x80 → PCF=0x80, InstrF_valid falls, next req_addr=0x80.
- Redirect coincident with imem_rsp_valid in S_WAIT → response discarded; S_REQ entered with addr=PC_In.
